// File: rtl/p1_action_controller.sv
// Player-1 action controller: position, facing, walk/attack FSM with frame-counted
// attack phases, hitbox flag and confirm pulse. Optional macro: P1_ATTACK_BUFFER_EN.
module p1_action_controller #(
  parameter int X_W             = 10,
  parameter int X_MIN           = 0,
  parameter int X_MAX           = 600,
  parameter int X_START         = 100,
  parameter int WALK_SPEED      = 3,
  parameter int STARTUP_FRAMES  = 4,
  parameter int ACTIVE_FRAMES   = 3,
  parameter int RECOVERY_FRAMES = 6
) (
  input  logic           clk_60Hz_game,
  input  logic           reset,
  input  logic           p1_move_left_cmd_in,
  input  logic           p1_move_right_cmd_in,
  input  logic           p1_attack_cmd_in,
  input  logic           p1_confirm_cmd_in,
  input  logic           game_active_in,
  output logic [X_W-1:0] p1_x_pos_out,
  output logic           p1_facing_right_out,
  output logic [2:0]     p1_state_out,
  output logic           p1_hitbox_active_out,
  output logic           p1_confirm_pulse_out
);

  typedef enum logic [2:0] {
    S_IDLE         = 3'd0,
    S_WALK         = 3'd1,
    S_ATK_STARTUP  = 3'd2,
    S_ATK_ACTIVE   = 3'd3,
    S_ATK_RECOVERY = 3'd4
  } state_t;

  // The counter only ever holds a phase length minus one.
  localparam int MAX_SA  = (STARTUP_FRAMES > ACTIVE_FRAMES) ? STARTUP_FRAMES : ACTIVE_FRAMES;
  localparam int CNT_MAX = (MAX_SA > RECOVERY_FRAMES) ? MAX_SA : RECOVERY_FRAMES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] ST_LOAD  = CNT_W'(STARTUP_FRAMES - 1);
  localparam logic [CNT_W-1:0] ACT_LOAD = CNT_W'(ACTIVE_FRAMES - 1);
  localparam logic [CNT_W-1:0] REC_LOAD = CNT_W'(RECOVERY_FRAMES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [X_W:0]   WALK_E  = (X_W+1)'(WALK_SPEED);
  localparam logic [X_W:0]   XMIN_E  = (X_W+1)'(X_MIN);
  localparam logic [X_W:0]   XMAX_E  = (X_W+1)'(X_MAX);
  localparam logic [X_W-1:0] XMIN_V  = X_W'(X_MIN);
  localparam logic [X_W-1:0] XMAX_V  = X_W'(X_MAX);
  localparam logic [X_W-1:0] XSTRT_V = X_W'(X_START);

  state_t           r_state, w_state_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic [X_W-1:0]   r_x, w_x_next;
  logic             r_facing, w_facing_next;
  logic             r_atk_prev, r_confirm_prev;
  logic             r_hitbox, r_confirm_pulse;
  logic             w_atk_edge;
  logic [X_W:0]     w_x_left, w_x_right;
`ifdef P1_ATTACK_BUFFER_EN
  logic             r_buf, w_buf_next;
`endif

  assign w_atk_edge = p1_attack_cmd_in & ~r_atk_prev;

  // One extra bit lets an underflow show up as bit X_W instead of wrapping.
  assign w_x_left  = {1'b0, r_x} - WALK_E;
  assign w_x_right = {1'b0, r_x} + WALK_E;

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_x_next      = r_x;
    w_facing_next = r_facing;
`ifdef P1_ATTACK_BUFFER_EN
    w_buf_next    = r_buf;
`endif
    case (r_state)
      S_IDLE, S_WALK: begin
        if (w_atk_edge) begin
          w_state_next = S_ATK_STARTUP;
          w_cnt_next   = ST_LOAD;
        end else if (p1_move_left_cmd_in && !p1_move_right_cmd_in) begin
          w_x_next      = (w_x_left[X_W] || (w_x_left < XMIN_E)) ? XMIN_V : w_x_left[X_W-1:0];
          w_facing_next = 1'b0;
          w_state_next  = S_WALK;
        end else if (p1_move_right_cmd_in && !p1_move_left_cmd_in) begin
          w_x_next      = (w_x_right > XMAX_E) ? XMAX_V : w_x_right[X_W-1:0];
          w_facing_next = 1'b1;
          w_state_next  = S_WALK;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_ATK_STARTUP: begin
        if (r_cnt == '0) begin
          w_state_next = S_ATK_ACTIVE;
          w_cnt_next   = ACT_LOAD;
        end else begin
          w_cnt_next = r_cnt - CNT_ONE;
        end
      end
      S_ATK_ACTIVE: begin
`ifdef P1_ATTACK_BUFFER_EN
        if (w_atk_edge) w_buf_next = 1'b1;
`endif
        if (r_cnt == '0) begin
          w_state_next = S_ATK_RECOVERY;
          w_cnt_next   = REC_LOAD;
        end else begin
          w_cnt_next = r_cnt - CNT_ONE;
        end
      end
      S_ATK_RECOVERY: begin
`ifdef P1_ATTACK_BUFFER_EN
        if (w_atk_edge) w_buf_next = 1'b1;
`endif
        if (r_cnt == '0) begin
`ifdef P1_ATTACK_BUFFER_EN
          if (w_buf_next) begin
            w_state_next = S_ATK_STARTUP;
            w_cnt_next   = ST_LOAD;
            w_buf_next   = 1'b0;
          end else
`endif
          begin
            w_state_next = S_IDLE;
            w_cnt_next   = '0;
          end
        end else begin
          w_cnt_next = r_cnt - CNT_ONE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
      end
    endcase

    // Menu/pause aborts any attack; position and facing freeze.
    if (!game_active_in) begin
      w_state_next  = S_IDLE;
      w_cnt_next    = '0;
      w_x_next      = r_x;
      w_facing_next = r_facing;
`ifdef P1_ATTACK_BUFFER_EN
      w_buf_next    = 1'b0;
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_60Hz_game or posedge reset) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_cnt           <= '0;
      r_x             <= XSTRT_V;
      r_facing        <= 1'b1;
      r_atk_prev      <= 1'b0;
      r_confirm_prev  <= 1'b0;
      r_hitbox        <= 1'b0;
      r_confirm_pulse <= 1'b0;
`ifdef P1_ATTACK_BUFFER_EN
      r_buf           <= 1'b0;
`endif
    end else begin
      r_state         <= w_state_next;
      r_cnt           <= w_cnt_next;
      r_x             <= w_x_next;
      r_facing        <= w_facing_next;
      r_atk_prev      <= p1_attack_cmd_in;
      r_confirm_prev  <= p1_confirm_cmd_in;
      r_hitbox        <= (w_state_next == S_ATK_ACTIVE);
      r_confirm_pulse <= p1_confirm_cmd_in & ~r_confirm_prev;
`ifdef P1_ATTACK_BUFFER_EN
      r_buf           <= w_buf_next;
`endif
    end
  end

  assign p1_x_pos_out         = r_x;
  assign p1_facing_right_out  = r_facing;
  assign p1_state_out         = r_state;
  assign p1_hitbox_active_out = r_hitbox;
  assign p1_confirm_pulse_out = r_confirm_pulse;

endmodule

// File: tb/tb_p1_action_controller.sv
// Scoreboard bench for p1_action_controller: a behavioural model pushes expected
// outputs per frame; they are popped and compared one step after the clock edge.
module tb_p1_action_controller;

  localparam int X_MIN = 0, X_MAX = 600, X_START = 100, WS = 3;
  localparam int ST_F = 4, ACT_F = 3, REC_F = 6;
  localparam int IDLE = 0, WALK = 1, STARTUP = 2, ACTIVE = 3, RECOVERY = 4;

  typedef struct {
    int x;
    int face;
    int state;
    int hit;
    int pulse;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       l_cmd, r_cmd, a_cmd, c_cmd, g_act;
  logic [9:0] x_pos;
  logic       facing, hitbox, pulse;
  logic [2:0] state;

  always #5 clk = ~clk;

  p1_action_controller dut (
    .clk_60Hz_game        (clk),
    .reset                (reset),
    .p1_move_left_cmd_in  (l_cmd),
    .p1_move_right_cmd_in (r_cmd),
    .p1_attack_cmd_in     (a_cmd),
    .p1_confirm_cmd_in    (c_cmd),
    .game_active_in       (g_act),
    .p1_x_pos_out         (x_pos),
    .p1_facing_right_out  (facing),
    .p1_state_out         (state),
    .p1_hitbox_active_out (hitbox),
    .p1_confirm_pulse_out (pulse)
  );

  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];

  int m_x, m_face, m_state, m_cnt, m_buf, m_pulse;
  int m_atk_prev, m_conf_prev;

  task automatic check(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic model_reset();
    m_x = X_START; m_face = 1; m_state = IDLE; m_cnt = 0; m_buf = 0; m_pulse = 0;
    m_atk_prev = 0; m_conf_prev = 0;
    exp_q.delete();
  endtask

  task automatic model_step(input int l, input int r, input int a, input int c, input int g);
    int   edge_a;
    exp_t e;
    edge_a  = a & ~m_atk_prev;
    m_pulse = c & ~m_conf_prev;
    m_atk_prev  = a;
    m_conf_prev = c;
    if (g == 0) begin
      m_state = IDLE; m_cnt = 0; m_buf = 0;
    end else begin
      case (m_state)
        IDLE, WALK: begin
          if (edge_a == 1) begin
            m_state = STARTUP; m_cnt = ST_F - 1;
          end else if (l == 1 && r == 0) begin
            m_x = (m_x - WS < X_MIN) ? X_MIN : m_x - WS;
            m_face = 0; m_state = WALK;
          end else if (r == 1 && l == 0) begin
            m_x = (m_x + WS > X_MAX) ? X_MAX : m_x + WS;
            m_face = 1; m_state = WALK;
          end else m_state = IDLE;
        end
        STARTUP: if (m_cnt == 0) begin m_state = ACTIVE; m_cnt = ACT_F - 1; end else m_cnt--;
        ACTIVE: begin
`ifdef P1_ATTACK_BUFFER_EN
          if (edge_a == 1) m_buf = 1;
`endif
          if (m_cnt == 0) begin m_state = RECOVERY; m_cnt = REC_F - 1; end else m_cnt--;
        end
        default: begin
`ifdef P1_ATTACK_BUFFER_EN
          if (edge_a == 1) m_buf = 1;
`endif
          if (m_cnt == 0) begin
            if (m_buf == 1) begin m_state = STARTUP; m_cnt = ST_F - 1; m_buf = 0; end
            else begin m_state = IDLE; m_cnt = 0; end
          end else m_cnt--;
        end
      endcase
    end
    e.x = m_x; e.face = m_face; e.state = m_state;
    e.hit = (m_state == ACTIVE) ? 1 : 0; e.pulse = m_pulse;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic il, input logic ir, input logic ia, input logic ic, input logic ig);
    exp_t e;
    @(negedge clk);
    l_cmd = il; r_cmd = ir; a_cmd = ia; c_cmd = ic; g_act = ig;
    model_step(int'(il), int'(ir), int'(ia), int'(ic), int'(ig));
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 0, 1);
    end else begin
      e = exp_q.pop_front();
      check("sb_x", int'(x_pos), e.x);
      check("sb_facing", int'(facing), e.face);
      check("sb_state", int'(state), e.state);
      check("sb_hitbox", int'(hitbox), e.hit);
      check("sb_pulse", int'(pulse), e.pulse);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    l_cmd = 0; r_cmd = 0; a_cmd = 0; c_cmd = 0; g_act = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int prev_st;
    int after_rec;

    reset = 1'b1;
    l_cmd = 0; r_cmd = 0; a_cmd = 0; c_cmd = 0; g_act = 0;
    model_reset();
    #12;
    check("rst_x", int'(x_pos), 100);
    check("rst_facing", int'(facing), 1);
    check("rst_state", int'(state), 0);
    check("rst_hitbox", int'(hitbox), 0);
    check("rst_pulse", int'(pulse), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) step(0, 0, 0, 0, 0);
    check("idle_hold_x", int'(x_pos), 100);

    // Walk right ten frames, then release.
    repeat (10) step(0, 1, 0, 0, 1);
    check("walk_right_x", int'(x_pos), 130);
    check("walk_right_state", int'(state), 1);
    step(0, 0, 0, 0, 1);
    check("release_state", int'(state), 0);
    check("release_x", int'(x_pos), 130);

    // Walk left into the X_MIN clamp.
    apply_reset();
    repeat (33) step(1, 0, 0, 0, 1);
    check("left33_x", int'(x_pos), 1);
    repeat (7) step(1, 0, 0, 0, 1);
    check("left_clamp_x", int'(x_pos), 0);
    check("left_facing", int'(facing), 0);
    repeat (3) step(1, 1, 0, 0, 1);
    check("both_state", int'(state), 0);
    check("both_x", int'(x_pos), 0);

    // Walk right into the X_MAX clamp.
    repeat (205) step(0, 1, 0, 0, 1);
    check("right_clamp_x", int'(x_pos), 600);

    // Single-frame attack press: phase lengths 4/3/6.
    apply_reset();
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 14; i++) begin
      step(0, 0, (i == 0), 0, 1);
      check("atk_phase", int'(state), (i < 4) ? 2 : (i < 7) ? 3 : (i < 13) ? 4 : 0);
    end

    // Held attack triggers exactly one attack.
    cnt = 0; prev_st = int'(state);
    for (int i = 0; i < 30; i++) begin
      step(0, 0, 1, 0, 1);
      if (int'(state) == 2 && prev_st != 2) cnt++;
      prev_st = int'(state);
    end
    check("held_attack_count", cnt, 1);
    step(0, 0, 0, 0, 1);

    // Right held through an attack does not move the player.
    apply_reset();
    step(0, 1, 1, 0, 1);
    repeat (13) step(0, 1, 0, 0, 1);
    check("atk_move_state", int'(state), 0);
    check("atk_move_x", int'(x_pos), 100);
    step(0, 1, 0, 0, 1);
    check("post_atk_walk_x", int'(x_pos), 103);

    // Dropping game_active in the active phase aborts the attack.
    step(0, 0, 1, 0, 1);
    repeat (4) step(0, 0, 0, 0, 1);
    check("abort_pre_state", int'(state), 3);
    check("abort_pre_hitbox", int'(hitbox), 1);
    step(0, 0, 0, 0, 0);
    check("abort_state", int'(state), 0);
    check("abort_hitbox", int'(hitbox), 0);

    // Confirm pulse is one frame per press, with or without gameplay.
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 1, 0);
      if (pulse === 1'b1) cnt++;
    end
    check("confirm_pause_pulses", cnt, 1);
    step(0, 0, 0, 0, 1);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 1, 1);
      if (pulse === 1'b1) cnt++;
    end
    check("confirm_game_pulses", cnt, 1);
    step(0, 0, 0, 0, 1);

    // Second press during recovery: buffered restart only with the buffer feature.
    step(0, 0, 1, 0, 1);
    repeat (7) step(0, 0, 0, 0, 1);
    check("buf_in_recovery", int'(state), 4);
    step(0, 0, 1, 0, 1);
    after_rec = -1;
    for (int i = 0; i < 20 && after_rec < 0; i++) begin
      step(0, 0, 0, 0, 1);
      if (int'(state) != 4) after_rec = int'(state);
    end
`ifdef P1_ATTACK_BUFFER_EN
    check("recovery_exit_state", after_rec, 2);
`else
    check("recovery_exit_state", after_rec, 0);
`endif
    repeat (16) step(0, 0, 0, 0, 1);

    // Asynchronous reset in the middle of an attack.
    step(0, 1, 0, 0, 1);
    step(0, 0, 1, 0, 1);
    repeat (5) step(0, 0, 0, 0, 1);
    check("mid_atk_state", int'(state), 3);
    #2 reset = 1'b1;
    #1;
    check("async_rst_state", int'(state), 0);
    check("async_rst_hitbox", int'(hitbox), 0);
    check("async_rst_x", int'(x_pos), 100);
    @(negedge clk);
    reset = 1'b0;
    l_cmd = 0; r_cmd = 0; a_cmd = 0; c_cmd = 0; g_act = 0;
    model_reset();
    repeat (3) step(0, 0, 0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
